// File: rtl/ne16_package.sv
// Shared types for the NE16 controller slice.
package ne16_package;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

endpackage : ne16_package

// File: rtl/ne16_ctrl_counter.sv
// Wrapping tile counter: counts 0..lim_i-1 when enabled and flags its final value.
module ne16_ctrl_counter
    import ne16_package::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic [BITS-1:0] lim_i,
    output logic [BITS-1:0] cnt_o,
    output logic            last_o,
    output logic            wrap_o
);

    logic [BITS-1:0] cnt_d, cnt_q;

    // A zero limit (only possible straight out of reset) never matches, so last_o stays low.
    assign last_o = (cnt_q == lim_i - BITS'(1));
    assign wrap_o = en_i & last_o;
    assign cnt_o  = cnt_q;

    // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + BITS'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ne16_ctrl_counter

// File: rtl/ne16_ctrl_tile_iter.sv
// Tile index iterator: walks (k_out, i, j) with j fastest, one tuple per handshake.
module ne16_ctrl_tile_iter
    import ne16_package::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            test_mode_i,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [BITS-1:0] k_out_lim_i,
    input  logic [BITS-1:0] i_lim_i,
    input  logic [BITS-1:0] j_lim_i,
    output logic            idx_valid_o,
    input  logic            idx_ready_i,
    output logic [BITS-1:0] k_out_o,
    output logic [BITS-1:0] i_o,
    output logic [BITS-1:0] j_o,
    output logic            last_j_o,
    output logic            last_i_o,
    output logic            last_k_out_o,
    output logic            busy_o,
    output logic            done_o
);

    function automatic logic [BITS-1:0] sat_lim(input logic [BITS-1:0] v);
        return (v == '0) ? BITS'(1) : v;
    endfunction

    ctrl_state_e     state_d, state_q;
    logic [BITS-1:0] k_lim_q, i_lim_q, j_lim_q;
    logic            start_acc, handshake, cnt_clear;
    logic            j_wrap, i_wrap, k_wrap;
    logic            unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign start_acc = start_i & ~clear_i & (state_q == IDLE);
    assign handshake = (state_q == RUN) & idx_ready_i;
    assign cnt_clear = clear_i | start_acc;

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_acc) state_d = RUN;
                RUN:     if (handshake && last_j_o && last_i_o && last_k_out_o) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_lim_q <= '0;
            i_lim_q <= '0;
            j_lim_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                k_lim_q <= sat_lim(k_out_lim_i);
                i_lim_q <= sat_lim(i_lim_i);
                j_lim_q <= sat_lim(j_lim_i);
            end
        end
    end

    // Enables ripple combinationally: a handshake on the last j bumps i in the same edge.
    ne16_ctrl_counter #(.BITS(BITS)) u_cnt_j (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cnt_clear),
        .en_i    (handshake),
        .lim_i   (j_lim_q),
        .cnt_o   (j_o),
        .last_o  (last_j_o),
        .wrap_o  (j_wrap)
    );

    ne16_ctrl_counter #(.BITS(BITS)) u_cnt_i (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cnt_clear),
        .en_i    (j_wrap),
        .lim_i   (i_lim_q),
        .cnt_o   (i_o),
        .last_o  (last_i_o),
        .wrap_o  (i_wrap)
    );

    ne16_ctrl_counter #(.BITS(BITS)) u_cnt_k (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cnt_clear),
        .en_i    (i_wrap),
        .lim_i   (k_lim_q),
        .cnt_o   (k_out_o),
        .last_o  (last_k_out_o),
        .wrap_o  (k_wrap)
    );

    logic unused_k_wrap;
    assign unused_k_wrap = k_wrap;

    assign idx_valid_o = (state_q == RUN);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule : ne16_ctrl_tile_iter

// File: doc/ne16_ctrl_tile_iter.md
NE16_CTRL_TILE_ITER -- requirements
Module: ne16_ctrl_tile_iter

Interface
REQ-001 SHALL have parameter BITS, default 16, width of every limit and index.
REQ-002 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have test_mode_i  input  1  DFT mode, no functional effect.
REQ-005 SHALL have clear_i  input  1  synchronous soft clear.
REQ-006 SHALL have start_i  input  1  single-cycle job start pulse.
REQ-007 SHALL have k_out_lim_i, i_lim_i, j_lim_i  input  BITS each  tile counts per loop level.
REQ-008 SHALL have idx_valid_o  output  1  tile index tuple valid.
REQ-009 SHALL have idx_ready_i  input  1  consumer accepts tuple.
REQ-010 SHALL have k_out_o, i_o, j_o  output  BITS each  current tile indices.
REQ-011 SHALL have last_j_o, last_i_o, last_k_out_o  output  1 each  index at its level's final value.
REQ-012 SHALL have busy_o  output  1  job in progress; done_o  output  1  end-of-job pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start_i, RUN->DONE on handshake with all three last flags set, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL latch the three limits on the start_i cycle in IDLE; input limits are don't-care afterwards.
REQ-015 SHALL treat any limit of 0 as 1 when latching.
REQ-016 SHALL ignore start_i in RUN and DONE.
REQ-017 SHALL assert idx_valid_o exactly while in RUN, first tuple (0,0,0) in the cycle after start_i.
REQ-018 SHALL hold k_out_o, i_o, j_o and last flags stable while idx_valid_o=1 and idx_ready_i=0.
REQ-019 SHALL advance on handshake (idx_valid_o & idx_ready_i) only, new tuple visible next cycle, one tuple per cycle max.
REQ-020 SHALL iterate j innermost, then i, then k_out: j wraps to 0 after j_lim-1 and increments i; i wraps after i_lim-1 and increments k_out.
REQ-021 SHALL compute last_j_o as (j_o == j_lim-1), likewise last_i_o, last_k_out_o, combinationally from registered state only.
REQ-022 SHALL emit exactly k_out_lim*i_lim*j_lim handshakes per job.
REQ-023 SHALL assert done_o for exactly one cycle, in DONE, and busy_o in RUN and DONE.
REQ-024 SHALL on clear_i (priority over start_i and handshake) return to IDLE, zero indices, no done_o pulse.
REQ-025 SHALL allow start_i in the cycle after DONE (IDLE) to begin a new job with no gap beyond that.
REQ-026 SHALL have no combinational path from idx_ready_i to idx_valid_o.

Reset
REQ-027 SHALL on rst_ni low enter IDLE; idx_valid_o=0, busy_o=0, done_o=0, all indices 0, latched limits 0, last flags 0.
REQ-028 SHALL abort an in-flight job on reset or clear_i without emitting further tuples.

Structure
REQ-029 SHALL declare the FSM state enum (IDLE, RUN, DONE) in ne16_package.
REQ-030 SHALL instantiate ne16_ctrl_counter three times (j, i, k_out), enable chained from handshake and inner wrap, clear from clear_i or start_i.
REQ-031 SHALL keep the inter-counter wrap chain within one cycle; no extra pipeline stage.

Verification
REQ-032 SHALL cover limits (2,3,4), idx_ready_i=1 -> 24 consecutive tuples (0,0,0)..(1,2,3) j-fastest, done_o one cycle after tuple 24.
REQ-033 SHALL cover limits (1,1,1) -> single tuple (0,0,0) with all last flags 1, done_o next cycle.
REQ-034 SHALL cover limits (2,2,2) with random ready backpressure -> tuples stable while stalled, 8 handshakes, order unchanged.
REQ-035 SHALL cover limits (0,5,0) -> treated as (1,5,1), 5 tuples.
REQ-036 SHALL cover clear_i at tuple 3 of (2,2,2) -> idx_valid_o=0 next cycle, no done_o, next start_i restarts at (0,0,0).
REQ-037 SHALL cover start_i pulsed during RUN and limits changed mid-job -> ignored, sequence unchanged.
